multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_pkg.sv | 32 +++
 rtl/mcu_output_decode.sv | 86 ++++++++
 rtl/multicycle_control_unit.sv | 128 ++++++++++++
 tb/tb_multicycle_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode classes and ALU operation codes.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_JMP   = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic op_class_legal(input logic [2:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP: op_class_legal = 1'b1;
      default:                                         op_class_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational datapath-control decode from the current state, the latched
// opcode class and the live zero/mem_ready inputs.
module mcu_output_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [2:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       alu_src_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic [1:0] alu_op_o,
  output logic       instr_done_o
);

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    branch_o     = 1'b0;
    jump_o       = 1'b0;
    alu_op_o     = ALU_ADD;
    instr_done_o = 1'b0;
    case (state_e'(state_i))
      ST_FETCH: begin
        mem_req_o = 1'b1;
        // PC increment and IR load only on the cycle the fetch completes
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          alu_op_o   = ALU_ADD;
        end
      end
      ST_EXEC: begin
        case (op_i)
          OP_RTYPE: alu_op_o = ALU_FUNCT;
          OP_ADDI, OP_LW, OP_SW: begin
            alu_op_o  = ALU_ADD;
            alu_src_o = 1'b1;
          end
          OP_BEQ: begin
            alu_op_o     = ALU_SUB;
            branch_o     = 1'b1;
            pc_write_o   = zero_i;
            instr_done_o = 1'b1;
          end
          OP_JMP: begin
            jump_o       = 1'b1;
            pc_write_o   = 1'b1;
            instr_done_o = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req_o    = 1'b1;
        iord_o       = 1'b1;
        mem_we_o     = (op_i == OP_SW);
        instr_done_o = mem_ready_i && (op_i == OP_SW);
      end
      ST_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        reg_dst_o    = (op_i == OP_RTYPE);
        mem_to_reg_o = (op_i == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: holds state, latched opcode and memory wait
// counter; output decode is delegated to mcu_output_decode.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic [1:0]          alu_op,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                illegal,
  output logic                timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic                op_legal;
  logic                waiting;

  assign op_legal = ((op_q >> 3) == '0) && op_class_legal(op_q[2:0]);
  assign waiting  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    // The wait counter only survives while still stalled; any exit clears it
    if (waiting) begin
      if (wait_q == CNT_W'(WAIT_MAX - 1)) begin
        timeout_d = 1'b1;
        state_d   = ST_ERR;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          op_d    = opcode;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          if (!op_legal) begin
            illegal_d = 1'b1;
            state_d   = ST_ERR;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q[2:0])
            OP_RTYPE, OP_ADDI: state_d = ST_WB;
            OP_LW, OP_SW:      state_d = ST_MEM;
            default:           state_d = ST_FETCH;
          endcase
        end
        ST_MEM:  state_d = (op_q[2:0] == OP_LW) ? ST_WB : ST_FETCH;
        ST_WB:   state_d = ST_FETCH;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_ERR;
      endcase
    end
  end

  mcu_output_decode u_decode (
    .state_i      (state_q),
    .op_i         (op_q[2:0]),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .pc_write_o   (pc_write),
    .ir_write_o   (ir_write),
    .reg_dst_o    (reg_dst),
    .alu_src_o    (alu_src),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .branch_o     (branch),
    .jump_o       (jump),
    .alu_op_o     (alu_op),
    .instr_done_o (instr_done)
  );

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each cycle's expected output
// vector is queued when inputs are driven and compared mid-cycle.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, pc_write, ir_write;
  logic       reg_dst, alu_src, mem_to_reg, reg_write, branch, jump;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       instr_done, illegal, timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] sb_q[$];

  // Observation vector layout: {state, controls, alu_op, instr_done, illegal, timeout}
  localparam logic [18:0] S_F   = 19'h00000;
  localparam logic [18:0] S_D   = 19'h10000;
  localparam logic [18:0] S_E   = 19'h20000;
  localparam logic [18:0] S_M   = 19'h30000;
  localparam logic [18:0] S_W   = 19'h40000;
  localparam logic [18:0] S_ERR = 19'h50000;
  localparam logic [18:0] MREQ  = 19'h08000;
  localparam logic [18:0] MWE   = 19'h04000;
  localparam logic [18:0] IORD  = 19'h02000;
  localparam logic [18:0] PCW   = 19'h01000;
  localparam logic [18:0] IRW   = 19'h00800;
  localparam logic [18:0] RDST  = 19'h00400;
  localparam logic [18:0] ASRC  = 19'h00200;
  localparam logic [18:0] M2R   = 19'h00100;
  localparam logic [18:0] RW    = 19'h00080;
  localparam logic [18:0] BR    = 19'h00040;
  localparam logic [18:0] JMP   = 19'h00020;
  localparam logic [18:0] AFN   = 19'h00010;
  localparam logic [18:0] ASUB  = 19'h00008;
  localparam logic [18:0] DONE  = 19'h00004;
  localparam logic [18:0] ILL   = 19'h00002;
  localparam logic [18:0] TMO   = 19'h00001;
  localparam logic [18:0] FETCHED = S_F | MREQ | PCW | IRW;

  multicycle_control_unit #(.OPCODE_W(3), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .branch     (branch),
    .jump       (jump),
    .alu_op     (alu_op),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {state, mem_req, mem_we, iord, pc_write, ir_write, reg_dst, alu_src,
            mem_to_reg, reg_write, branch, jump, alu_op, instr_done, illegal, timeout};
  endfunction

  task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%05h expected=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; drives one cycle of inputs and checks it.
  task automatic cyc(input string tag, input logic [2:0] op, input logic z,
                     input logic rdy, input logic [18:0] e);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    sb_q.push_back(e);
    @(negedge clk);
    check_eq(tag, obs(), sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 3'b000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset0", 3'b000, 0, 0, S_F | MREQ);
    cyc("reset1", 3'b111, 1, 0, S_F | MREQ);
    rst = 1'b0;

    // RTYPE
    cyc("rt_fetch",  3'b000, 0, 1, FETCHED);
    cyc("rt_decode", 3'b011, 0, 1, S_D);
    cyc("rt_exec",   3'b011, 0, 1, S_E | AFN);
    cyc("rt_wb",     3'b011, 0, 1, S_W | RW | RDST | DONE);

    // ADDI after a short fetch stall
    cyc("ad_wait0",  3'b001, 0, 0, S_F | MREQ);
    cyc("ad_wait1",  3'b001, 0, 0, S_F | MREQ);
    cyc("ad_fetch",  3'b001, 0, 1, FETCHED);
    cyc("ad_decode", 3'b000, 0, 1, S_D);
    cyc("ad_exec",   3'b000, 0, 1, S_E | ASRC);
    cyc("ad_wb",     3'b000, 0, 1, S_W | RW | DONE);

    // LW with three MEM wait cycles: 8 cycles total
    cyc("lw_fetch",  3'b100, 0, 1, FETCHED);
    cyc("lw_decode", 3'b000, 0, 1, S_D);
    cyc("lw_exec",   3'b000, 0, 1, S_E | ASRC);
    for (int i = 0; i < 3; i++) cyc("lw_memwait", 3'b000, 0, 0, S_M | MREQ | IORD);
    cyc("lw_mem",    3'b000, 0, 1, S_M | MREQ | IORD);
    cyc("lw_wb",     3'b000, 0, 1, S_W | RW | M2R | DONE);

    // SW
    cyc("sw_fetch",  3'b101, 0, 1, FETCHED);
    cyc("sw_decode", 3'b000, 0, 1, S_D);
    cyc("sw_exec",   3'b000, 0, 1, S_E | ASRC);
    cyc("sw_mem",    3'b000, 0, 1, S_M | MREQ | IORD | MWE | DONE);

    // BEQ taken / not taken
    cyc("beq1_fetch",  3'b110, 0, 1, FETCHED);
    cyc("beq1_decode", 3'b000, 0, 1, S_D);
    cyc("beq1_exec",   3'b000, 1, 1, S_E | ASUB | BR | PCW | DONE);
    cyc("beq0_fetch",  3'b110, 1, 1, FETCHED);
    cyc("beq0_decode", 3'b000, 1, 1, S_D);
    cyc("beq0_exec",   3'b000, 0, 1, S_E | ASUB | BR | DONE);

    // JMP
    cyc("jmp_fetch",  3'b111, 0, 1, FETCHED);
    cyc("jmp_decode", 3'b000, 0, 1, S_D);
    cyc("jmp_exec",   3'b000, 0, 1, S_E | JMP | PCW | DONE);

    // Fetch timeout: 15 stalled cycles then ERR, sticky
    for (int i = 0; i < 15; i++) cyc("to_wait", 3'b000, 0, 0, S_F | MREQ);
    for (int i = 0; i < 4; i++) cyc("to_err", 3'b000, 1, 1, S_ERR | TMO);

    // Illegal opcodes
    for (int k = 0; k < 2; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'b010 : 3'b011;
      do_reset();
      cyc("il_fetch",  bad,    0, 1, FETCHED);
      cyc("il_decode", 3'b000, 0, 1, S_D);
      for (int i = 0; i < 10; i++)
        cyc("il_err", 3'(i), i[0], 1, S_ERR | ILL);
    end

    // Asynchronous reset during SW memory stall, then restart
    do_reset();
    cyc("ar_fetch",  3'b101, 0, 1, FETCHED);
    cyc("ar_decode", 3'b000, 0, 1, S_D);
    cyc("ar_exec",   3'b000, 0, 1, S_E | ASRC);
    cyc("ar_mem",    3'b000, 0, 0, S_M | MREQ | IORD | MWE);
    rst = 1'b1;
    #1;
    sb_q.push_back(S_F | MREQ);
    check_eq("ar_async", obs(), sb_q.pop_front());
    cyc("ar_held",   3'b000, 0, 1, FETCHED);
    rst = 1'b0;
    cyc("rs_fetch",  3'b001, 0, 1, FETCHED);
    cyc("rs_decode", 3'b000, 0, 1, S_D);
    cyc("rs_exec",   3'b000, 0, 1, S_E | ASRC);
    cyc("rs_wb",     3'b000, 0, 1, S_W | RW | DONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
